// File: rtl/switch_port_collector.sv
// Per-port capture FIFOs on the switch outputs, drained through one registered read port.
// Pop-to-rd_valid latency 1 cycle; pushes to a full port are dropped and flagged sticky in overflow.

module spc_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16,
   parameter int CNT_W = $clog2(DEPTH)+1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdat,
   output logic [W-1:0]     rdat,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   // A pop frees the slot the same-cycle push lands in, so full+pop still accepts.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem[wr_ptr] <= wdat;
   end

   assign rdat  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
endmodule

module switch_port_collector #(
   parameter int NUM_PORTS = 4,
   parameter int DEPTH     = 4,
   parameter int DATA_W    = 8,
   parameter int CNT_W     = $clog2(DEPTH)+1
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        valid_out,
   input  logic [NUM_PORTS*DATA_W-1:0] data_out,
   input  logic [NUM_PORTS*DATA_W-1:0] addr_out,
   input  logic [1:0]                  rd_port,
   input  logic                        rd_req,
   input  logic [NUM_PORTS-1:0]        ovf_clr,
   output logic                        rd_valid,
   output logic [DATA_W-1:0]           rd_data,
   output logic [DATA_W-1:0]           rd_addr,
   output logic [NUM_PORTS*CNT_W-1:0]  count,
   output logic [NUM_PORTS-1:0]        empty,
   output logic [NUM_PORTS-1:0]        full,
   output logic [NUM_PORTS-1:0]        overflow
);
   logic [NUM_PORTS-1:0] push, pop_sel, drop;
   logic [2*DATA_W-1:0]  head [NUM_PORTS];
   logic                 pop_ok;

   // The switch tri-states during its own reset; only a clean 1 is a push.
   always_comb begin
      push    = '0;
      pop_sel = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         push[p]    = (valid_out[p] === 1'b1);
         pop_sel[p] = rd_req && (rd_port == 2'(p));
      end
   end

   assign pop_ok = rd_req && !empty[rd_port];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      spc_fifo #(.DEPTH(DEPTH), .W(2*DATA_W), .CNT_W(CNT_W)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[g]),
         .pop   (pop_sel[g]),
         .wdat  ({addr_out[g*DATA_W+:DATA_W], data_out[g*DATA_W+:DATA_W]}),
         .rdat  (head[g]),
         .count (count[g*CNT_W+:CNT_W]),
         .full  (full[g]),
         .empty (empty[g])
      );
      // Full implies non-empty, so a same-port pop always makes room.
      assign drop[g] = push[g] && full[g] && !pop_sel[g];
   end

   always_ff @(posedge clk) begin
      if (reset) overflow <= '0;
      else       overflow <= drop | (overflow & ~ovf_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_addr  <= '0;
      end else begin
         rd_valid <= pop_ok;
         if (pop_ok) {rd_addr, rd_data} <= head[rd_port];
      end
   end
endmodule

// File: tb/tb_switch_port_collector.sv
// Bench for switch_port_collector: directed scenarios plus a randomized run,
// all tracked by a queue-based reference model advanced on every clock.

module tb_switch_port_collector;
   localparam int NP = 4;
   localparam int DEPTH = 4;
   localparam int CW = 3;

   logic          clk = 0;
   logic          reset;
   logic [3:0]    valid_out;
   logic [31:0]   data_out, addr_out;
   logic [1:0]    rd_port;
   logic          rd_req;
   logic [3:0]    ovf_clr;
   logic          rd_valid;
   logic [7:0]    rd_data, rd_addr;
   logic [11:0]   count;
   logic [3:0]    empty, full, overflow;

   int total = 0;
   int bad = 0;

   logic [15:0] q [NP][$];
   logic [3:0]  m_ovf;
   logic        m_rv;
   logic [7:0]  m_rd, m_ra;

   switch_port_collector dut (
      .clk(clk), .reset(reset), .valid_out(valid_out), .data_out(data_out),
      .addr_out(addr_out), .rd_port(rd_port), .rd_req(rd_req), .ovf_clr(ovf_clr),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .count(count),
      .empty(empty), .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] cnt(input int p);
      return count[p*CW+:CW];
   endfunction

   // Advance the reference model with the inputs currently applied, then clock.
   task automatic tick();
      logic [15:0] e;
      logic        dr;
      if (reset === 1'b1) begin
         for (int p = 0; p < NP; p++) q[p].delete();
         m_ovf = '0; m_rv = 0; m_rd = '0; m_ra = '0;
      end else begin
         m_rv = 0;
         if (rd_req === 1'b1 && q[rd_port].size() > 0) begin
            e = q[rd_port].pop_front();
            m_rv = 1; m_rd = e[7:0]; m_ra = e[15:8];
         end
         for (int p = 0; p < NP; p++) begin
            dr = 0;
            if (valid_out[p] === 1'b1) begin
               if (q[p].size() < DEPTH) q[p].push_back({addr_out[p*8+:8], data_out[p*8+:8]});
               else dr = 1;
            end
            if (dr) m_ovf[p] = 1'b1;
            else if (ovf_clr[p]) m_ovf[p] = 1'b0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      valid_out = '0; rd_req = 0; ovf_clr = '0;
   endtask

   task automatic test_reset();
      reset = 1; valid_out = 'z; data_out = 'z; addr_out = 'z;
      rd_port = 0; rd_req = 0; ovf_clr = '0;
      tick(); tick();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
      total++; if (rd_addr !== 8'h00) begin bad++; $display("FAIL reset_rd_addr got=%h exp=00", rd_addr); end
      total++; if (count !== 12'h000) begin bad++; $display("FAIL reset_count got=%h exp=000", count); end
      total++; if (empty !== 4'hF) begin bad++; $display("FAIL reset_empty got=%h exp=F", empty); end
      total++; if (full !== 4'h0) begin bad++; $display("FAIL reset_full got=%h exp=0", full); end
      total++; if (overflow !== 4'h0) begin bad++; $display("FAIL reset_overflow got=%h exp=0", overflow); end
      reset = 0; data_out = '0; addr_out = '0; idle();
      tick();
   endtask

   task automatic test_single();
      valid_out = 4'b0010; data_out = 32'h0000_A500; addr_out = 32'h0000_0100;
      tick(); idle();
      total++; if (cnt(1) !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", cnt(1)); end
      total++; if (empty[1] !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", empty[1]); end
      rd_port = 1; rd_req = 1;
      tick(); idle();
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_rd_valid got=%b exp=1", rd_valid); end
      total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_rd_data got=%h exp=A5", rd_data); end
      total++; if (rd_addr !== 8'h01) begin bad++; $display("FAIL single_rd_addr got=%h exp=01", rd_addr); end
      total++; if (cnt(1) !== 3'd0) begin bad++; $display("FAIL single_count_after got=%0d exp=0", cnt(1)); end
      tick();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_rd_valid_drop got=%b exp=0", rd_valid); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) begin
         valid_out = 4'b0100; data_out = {8'h00, 8'h10 + 8'(i), 16'h0000}; addr_out = {8'h00, 8'h20 + 8'(i), 16'h0000};
         tick();
         if (i == 3) begin
            total++; if (full[2] !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full[2]); end
            total++; if (overflow[2] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow[2]); end
         end
      end
      idle();
      total++; if (overflow[2] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow[2]); end
      total++; if (cnt(2) !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", cnt(2)); end
      for (int i = 0; i < 5; i++) begin
         rd_port = 2; rd_req = 1;
         tick();
         if (i < 4) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'h10 + 8'(i)); end
         end else begin
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty_pop got=%b exp=0", rd_valid); end
            total++; if (rd_data !== 8'h13) begin bad++; $display("FAIL ovf_hold got=%h exp=13", rd_data); end
         end
      end
      idle();
      ovf_clr = 4'b0100;
      tick(); idle();
      total++; if (overflow[2] !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow[2]); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) begin
         valid_out = 4'b1000; data_out = {8'h30 + 8'(i), 24'h0}; addr_out = {8'h03, 24'h0};
         tick();
      end
      valid_out = 4'b1000; data_out = {8'h77, 24'h0}; rd_port = 3; rd_req = 1;
      tick(); idle();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'h30) begin bad++; $display("FAIL fpp_pop got=%b/%h exp=1/30", rd_valid, rd_data); end
      total++; if (cnt(3) !== 3'd4) begin bad++; $display("FAIL fpp_count got=%0d exp=4", cnt(3)); end
      total++; if (overflow[3] !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b exp=0", overflow[3]); end
      for (int i = 1; i < 5; i++) begin
         rd_port = 3; rd_req = 1;
         tick();
         total++; if (rd_data !== ((i == 4) ? 8'h77 : 8'h30 + 8'(i))) begin bad++; $display("FAIL fpp_drain%0d got=%h", i, rd_data); end
      end
      idle();
   endtask

   task automatic test_all_ports();
      valid_out = 4'hF; data_out = 32'hA3A2_A1A0; addr_out = 32'h0302_0100;
      tick(); idle();
      total++; if (count !== {3'd1, 3'd1, 3'd1, 3'd1}) begin bad++; $display("FAIL all_count got=%h exp=249", count); end
      for (int p = 3; p >= 0; p--) begin
         rd_port = 2'(p); rd_req = 1;
         tick();
         total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(p) || rd_addr !== 8'(p)) begin bad++; $display("FAIL all_pop%0d got=%b/%h/%h", p, rd_valid, rd_data, rd_addr); end
      end
      idle();
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) begin
         valid_out = 4'b0010; data_out = {16'h0, 8'h50 + 8'(i), 8'h0};
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         valid_out = 4'b0001; data_out = {24'h0, 8'h60 + 8'(i)};
         tick();
      end
      idle();
      total++; if (overflow[1] !== 1'b1 || cnt(0) !== 3'd3) begin bad++; $display("FAIL mrst_pre got=%b/%0d exp=1/3", overflow[1], cnt(0)); end
      reset = 1; valid_out = 4'b0001; rd_req = 1; rd_port = 0;
      tick();
      reset = 0; idle();
      total++; if (count !== 12'h000) begin bad++; $display("FAIL mrst_count got=%h exp=000", count); end
      total++; if (overflow !== 4'h0) begin bad++; $display("FAIL mrst_overflow got=%h exp=0", overflow); end
      rd_port = 0; rd_req = 1;
      tick(); idle();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mrst_pop got=%b exp=0", rd_valid); end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 2000; c++) begin
         reset = ($urandom_range(99) == 0);
         for (int p = 0; p < NP; p++) begin
            r = $urandom_range(9);
            valid_out[p] = (r == 0) ? 1'bx : (r < 5);
         end
         data_out = $urandom; addr_out = $urandom;
         rd_req = ($urandom_range(2) != 0); rd_port = 2'($urandom);
         ovf_clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
         tick();
         total++; if (rd_valid !== m_rv || rd_data !== m_rd || rd_addr !== m_ra) begin bad++; $display("FAIL rnd_read c=%0d got=%b/%h/%h exp=%b/%h/%h", c, rd_valid, rd_data, rd_addr, m_rv, m_rd, m_ra); end
         total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow c=%0d got=%h exp=%h", c, overflow, m_ovf); end
         for (int p = 0; p < NP; p++) begin
            total++;
            if (cnt(p) !== 3'(q[p].size()) || empty[p] !== (q[p].size() == 0) || full[p] !== (q[p].size() == DEPTH)) begin
               bad++; $display("FAIL rnd_status c=%0d p=%0d got=%0d/%b/%b exp=%0d", c, p, cnt(p), empty[p], full[p], q[p].size());
            end
         end
      end
      reset = 0; idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_all_ports();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
